// File: rtl/ucq_pkg.sv
// Shared definitions for the unit-clause queue write-port arbiter.
// The literal width covers every literal index plus a polarity bit.
package ucq_pkg;

  localparam int LIT_IDX_MAX = 255;
  localparam int LIT_W       = $clog2(LIT_IDX_MAX) + 1;
  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 16;

  typedef logic [LIT_W-1:0] lit_t;

endpackage

// File: rtl/ucq_arbiter_rr_pick.sv
// Rotating priority encoder. The search starts at i_ptr and wraps modulo NUM_REQ.
// It returns the first requester found, as a one-hot grant and as a binary index.
module rr_pick
  import ucq_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_any,
  output logic [PTR_W-1:0]   o_idx
);

  logic [PTR_W:0] w_sum;

  // Scan from the farthest offset down to offset 0, so the closest requester
  // at or after the pointer is the last one written and therefore wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
      if (w_sum >= (PTR_W + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W + 1)'(NUM_REQ);
      end
      if (i_req[w_sum[PTR_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ucq_arbiter.sv
// Round-robin arbiter that shares the uc_queue write port among the UCA requesters.
// A literal is pushed in the cycle it is offered; same-cycle duplicates are acknowledged and dropped.
module ucq_arbiter
  import ucq_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LIT_W   = ucq_pkg::LIT_W,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0][LIT_W-1:0] i_req_lit,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_ucq_full,
  output logic                          o_ucq_push,
  output logic [LIT_W-1:0]              o_ucq_lit,
  input  logic                          i_flush,
  output logic [CNT_W-1:0]              o_push_cnt,
  output logic [CNT_W-1:0]              o_drop_cnt
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int DROP_W = $clog2(NUM_REQ + 1);

  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_push_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_dup;
  logic               w_any;
  logic               w_fire;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [LIT_W-1:0]   w_win_lit;
  logic [DROP_W-1:0]  w_drop_n;
  logic [CNT_W:0]     w_push_sum;
  logic [CNT_W:0]     w_drop_sum;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any),
    .o_idx   (w_idx)
  );

  assign w_win_lit = i_req_lit[w_idx];

  // Reset blocks the port outright. Flush only clears state, so a push can still happen in a flush cycle.
  assign w_fire = w_any & ~i_ucq_full & ~i_rst;

  always_comb begin
    w_dup = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dup[j] = i_req_valid[j] & ~w_grant[j] & (i_req_lit[j] == w_win_lit);
    end
  end

  assign w_drop_n   = DROP_W'($countones(w_dup));
  assign w_ptr_nxt  = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_push_sum = {1'b0, r_push_cnt} + (CNT_W + 1)'(1);
  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_drop_n);

  assign o_ucq_push  = w_fire;
  assign o_ucq_lit   = w_fire ? w_win_lit : '0;
  assign o_req_ready = w_fire ? (w_grant | w_dup) : '0;
  assign o_push_cnt  = r_push_cnt;
  assign o_drop_cnt  = r_drop_cnt;

  // The carry bit of each sum marks an overflow, so the counter pins at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_ptr      <= '0;
      r_push_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (w_fire) begin
      r_ptr      <= w_ptr_nxt;
      r_push_cnt <= w_push_sum[CNT_W] ? '1 : w_push_sum[CNT_W-1:0];
      r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_ucq_arbiter.sv
// Directed bench for ucq_arbiter with four requesters and narrow counters, so saturation can be reached.
module tb_ucq_arbiter;
  import ucq_pkg::*;

  logic              clk;
  logic              rst;
  logic [3:0]        req_valid;
  lit_t [3:0]        req_lit;
  logic [3:0]        req_ready;
  logic              ucq_full;
  logic              ucq_push;
  lit_t              ucq_lit;
  logic              flush;
  logic [3:0]        push_cnt;
  logic [3:0]        drop_cnt;

  int checks   = 0;
  int failures = 0;

  ucq_arbiter #(
    .NUM_REQ (4),
    .LIT_W   (LIT_W),
    .CNT_W   (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_lit   (req_lit),
    .o_req_ready (req_ready),
    .i_ucq_full  (ucq_full),
    .o_ucq_push  (ucq_push),
    .o_ucq_lit   (ucq_lit),
    .i_flush     (flush),
    .o_push_cnt  (push_cnt),
    .o_drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b0001;
    req_lit[0] = 9'd3;
    #1;
    checks++;
    if (ucq_push !== 1'b0) begin failures++; $display("FAIL rst_push got=%0h exp=0", ucq_push); end
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    step();
    rst = 1'b0;
    req_valid = 4'b0000;
    step(); step(); step();
    checks++;
    if (ucq_push !== 1'b0 || ucq_lit !== 9'd0 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL idle_outputs got push=%0h lit=%0d ready=%b exp 0/0/0000", ucq_push, ucq_lit, req_ready);
    end
    checks++;
    if (push_cnt !== 4'd0 || drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL idle_counts got push=%0d drop=%0d exp 0/0", push_cnt, drop_cnt);
    end
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_lit[2] = 9'd6;
    #1;
    checks++;
    if (ucq_push !== 1'b1 || ucq_lit !== 9'd6 || req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single got push=%0h lit=%0d ready=%b exp 1/6/0100", ucq_push, ucq_lit, req_ready);
    end
    step();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (push_cnt !== 4'd1 || drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL single_cnt got push=%0d drop=%0d exp 1/0", push_cnt, drop_cnt);
    end
    // The pointer now sits at 3, so requester 3 beats requester 0.
    req_valid = 4'b1001;
    req_lit[0] = 9'd5;
    req_lit[3] = 9'd7;
    #1;
    checks++;
    if (ucq_lit !== 9'd7 || req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL single_ptr got lit=%0d ready=%b exp 7/1000", ucq_lit, req_ready);
    end
    step();
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    lit_t exp_lit [4];
    exp_lit = '{9'd2, 9'd4, 9'd8, 9'd10};
    do_flush();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) req_lit[k] = exp_lit[k];
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (ucq_push !== 1'b1 || ucq_lit !== exp_lit[k] || req_ready !== 4'(1 << k)) begin
        failures++;
        $display("FAIL rr_grant%0d got push=%0h lit=%0d ready=%b exp 1/%0d/%b",
                 k, ucq_push, ucq_lit, req_ready, exp_lit[k], 4'(1 << k));
      end
      step();
      req_valid[k] = 1'b0;
    end
    #1;
    checks++;
    if (push_cnt !== 4'd4 || drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL rr_cnt got push=%0d drop=%0d exp 4/0", push_cnt, drop_cnt);
    end
  endtask

  task automatic test_duplicate();
    do_flush();
    req_valid = 4'b1011;
    req_lit[0] = 9'd4;
    req_lit[1] = 9'd4;
    req_lit[2] = 9'd4;
    req_lit[3] = 9'd6;
    #1;
    checks++;
    if (ucq_push !== 1'b1 || ucq_lit !== 9'd4 || req_ready !== 4'b0011) begin
      failures++;
      $display("FAIL dup_c1 got push=%0h lit=%0d ready=%b exp 1/4/0011", ucq_push, ucq_lit, req_ready);
    end
    step();
    req_valid = 4'b1000;
    #1;
    checks++;
    if (drop_cnt !== 4'd1 || push_cnt !== 4'd1) begin
      failures++;
      $display("FAIL dup_cnt1 got push=%0d drop=%0d exp 1/1", push_cnt, drop_cnt);
    end
    checks++;
    if (ucq_lit !== 9'd6 || req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL dup_c2 got lit=%0d ready=%b exp 6/1000", ucq_lit, req_ready);
    end
    step();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (push_cnt !== 4'd2 || drop_cnt !== 4'd1) begin
      failures++;
      $display("FAIL dup_cnt2 got push=%0d drop=%0d exp 2/1", push_cnt, drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_flush();
    ucq_full = 1'b1;
    req_valid = 4'b0010;
    req_lit[1] = 9'd8;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ucq_push !== 1'b0 || ucq_lit !== 9'd0 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_full%0d got push=%0h lit=%0d ready=%b exp 0/0/0000", c, ucq_push, ucq_lit, req_ready);
      end
      step();
    end
    checks++;
    if (push_cnt !== 4'd0) begin failures++; $display("FAIL bp_hold_cnt got=%0d exp=0", push_cnt); end
    ucq_full = 1'b0;
    #1;
    checks++;
    if (ucq_push !== 1'b1 || ucq_lit !== 9'd8 || req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_release got push=%0h lit=%0d ready=%b exp 1/8/0010", ucq_push, ucq_lit, req_ready);
    end
    step();
    // The pointer is now 2. While the queue is full it must not move, so requester 0 wins after release.
    ucq_full = 1'b1;
    req_valid = 4'b0011;
    req_lit[0] = 9'd3;
    req_lit[1] = 9'd5;
    step(); step();
    ucq_full = 1'b0;
    #1;
    checks++;
    if (ucq_lit !== 9'd3 || req_ready !== 4'b0001 || push_cnt !== 4'd1) begin
      failures++;
      $display("FAIL bp_ptr got lit=%0d ready=%b cnt=%0d exp 3/0001/1", ucq_lit, req_ready, push_cnt);
    end
    step();
    req_valid = 4'b0000;
  endtask

  task automatic test_back_to_back();
    do_flush();
    req_valid = 4'b0001;
    req_lit[0] = 9'd9;
    step();
    req_valid = 4'b0010;
    req_lit[1] = 9'd9;
    #1;
    checks++;
    if (ucq_push !== 1'b1 || ucq_lit !== 9'd9 || req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL b2b_repush got push=%0h lit=%0d ready=%b exp 1/9/0010", ucq_push, ucq_lit, req_ready);
    end
    step();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (push_cnt !== 4'd2 || drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL b2b_cnt got push=%0d drop=%0d exp 2/0", push_cnt, drop_cnt);
    end
  endtask

  task automatic test_flush_mid();
    do_flush();
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'(1 << k);
      req_lit[k] = 9'(2 * k + 1);
      step();
    end
    req_valid = 4'b0000;
    #1;
    checks++;
    if (push_cnt !== 4'd3) begin failures++; $display("FAIL flush_pre_cnt got=%0d exp=3", push_cnt); end
    flush = 1'b1;
    req_valid = 4'b0100;
    req_lit[2] = 9'd10;
    #1;
    checks++;
    if (ucq_push !== 1'b1 || ucq_lit !== 9'd10 || req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL flush_push got push=%0h lit=%0d ready=%b exp 1/10/0100", ucq_push, ucq_lit, req_ready);
    end
    step();
    flush = 1'b0;
    req_valid = 4'b0000;
    #1;
    checks++;
    if (push_cnt !== 4'd0 || drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL flush_cnt got push=%0d drop=%0d exp 0/0", push_cnt, drop_cnt);
    end
    req_valid = 4'b1001;
    req_lit[0] = 9'd11;
    req_lit[3] = 9'd13;
    #1;
    checks++;
    if (ucq_lit !== 9'd11 || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL flush_ptr got lit=%0d ready=%b exp 11/0001", ucq_lit, req_ready);
    end
    step();
    req_valid = 4'b0000;
  endtask

  task automatic test_saturation();
    do_flush();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) req_lit[k] = 9'd12;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c == 1) begin
        checks++;
        if (req_ready !== 4'b1111 || ucq_lit !== 9'd12) begin
          failures++;
          $display("FAIL sat_alldup got ready=%b lit=%0d exp 1111/12", req_ready, ucq_lit);
        end
      end
      step();
      if (c == 5) begin
        checks++;
        if (drop_cnt !== 4'd15) begin failures++; $display("FAIL sat_drop_edge got=%0d exp=15", drop_cnt); end
      end
    end
    checks++;
    if (drop_cnt !== 4'd15 || push_cnt !== 4'd6) begin
      failures++;
      $display("FAIL sat_drop got drop=%0d push=%0d exp 15/6", drop_cnt, push_cnt);
    end
    req_valid = 4'b0000;
    do_flush();
    req_valid = 4'b0001;
    req_lit[0] = 9'd1;
    repeat (16) step();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (push_cnt !== 4'd15 || drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL sat_push got push=%0d drop=%0d exp 15/0", push_cnt, drop_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ucq_full = 1'b0;
    req_valid = 4'b0000;
    req_lit = '0;
    step();
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_duplicate();
    test_backpressure();
    test_back_to_back();
    test_flush_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucq_arbiter.md
Name: ucq_arbiter

Overview:
- Shares the single unit-clause queue (uc_queue) write port among NUM_REQ unit-clause analyzer (UCA) requesters.
- Round-robin arbitration grants one requester per cycle. The granted literal drives the queue's push/uca2ucq inputs, gated by the queue's full flag.
- Other requesters offering the identical literal in the same cycle are acknowledged and dropped, so duplicate implications never enter the queue.
- Sits between the UCA array and uc_queue; keeps per-block push/drop statistics.

Parameters:
- NUM_REQ, 4, number of UCA requesters (2..16).
- LIT_W, $clog2(`LIT_IDX_MAX)+1, literal width; matches uc_queue data width.
- CNT_W, 16, statistics counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  requester i offers a literal
- req_lit  input  NUM_REQ x LIT_W  literal from requester i
- req_ready  output  NUM_REQ  literal of requester i consumed (pushed or dropped) this cycle
- ucq_full  input  1  full flag from uc_queue
- ucq_push  output  1  to uc_queue push
- ucq_lit  output  LIT_W  to uc_queue uca2ucq
- flush  input  1  synchronous clear of the arbitration pointer and statistics (new decision level)
- push_cnt  output  CNT_W  literals pushed since reset/flush
- drop_cnt  output  CNT_W  duplicate literals dropped since reset/flush

Behaviour:
- Combinational datapath, zero latency: a literal offered in cycle t is pushed in cycle t.
- State: rr_ptr (clog2(NUM_REQ) bits), push_cnt, drop_cnt.
  - Reset values: all 0; ucq_push=0, ucq_lit=0, req_ready=0.
  - flush has the same effect as rst.
- Grant selection: search from index rr_ptr upward, wrapping modulo NUM_REQ. The first i with req_valid[i]=1 is the winner w.
- If no req_valid is set:
  - ucq_push=0, ucq_lit=0, req_ready=0.
  - rr_ptr and both counters hold.
- If ucq_full=1:
  - ucq_push=0, req_ready=0 for all requesters; the winner is not consumed.
  - rr_ptr and both counters hold.
  - Requesters must hold valid/lit stable until ready.
- If a winner exists and ucq_full=0:
  - ucq_push=1, ucq_lit=req_lit[w], req_ready[w]=1.
  - For every j≠w with req_valid[j]=1 and req_lit[j]==req_lit[w]: req_ready[j]=1, no push (duplicate dropped).
  - rr_ptr <= (w+1) mod NUM_REQ.
  - push_cnt += 1; drop_cnt += number of dropped duplicates.
- Non-winning, non-duplicate requesters: req_ready=0; they retry next cycle.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- ucq_lit is forced to 0 when ucq_push=0, so the port is idle-clean.
- Duplicate detection is same-cycle only. The same literal arriving in a later cycle is pushed again.
- rst or flush asserted in a cycle overrides all other updates. Outputs still follow the combinational rules that cycle, except:
  - req_ready=0 and ucq_push=0 while rst=1.
  - flush does not block a push.
- Fairness: any requester holding valid while the queue is never full is granted within NUM_REQ cycles.

Decomposition:
- Shared package (ucq_pkg): LIT_W, NUM_REQ default, literal typedef lit_t.
- One sub-module: rr_pick.
  - Function: rotating priority encoder.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, any, binary index.
- Duplicate comparators, counters and pointer stay in ucq_arbiter.

Test Plan:
- Reset then idle: all req_valid=0 for 3 cycles -> ucq_push=0, ucq_lit=0, req_ready=0, counters 0.
- Single requester: req 2 offers lit 6 with ucq_full=0 -> ucq_push=1, ucq_lit=6, req_ready=4'b0100 same cycle; rr_ptr=3; push_cnt=1.
- Round-robin: all four valid with lits 2,4,8,10, held until ready.
  - Grants in order 0,1,2,3, one per cycle; ucq_lit sequence 2,4,8,10.
  - push_cnt=4; drop_cnt=0.
- Duplicate drop: req0=lit 4, req1=lit 4, req3=lit 6, rr_ptr=0.
  - Cycle 1: push 4, ready=4'b0011, drop_cnt=1.
  - Cycle 2: push 6, ready=4'b1000; push_cnt=2.
- Backpressure: ucq_full=1 with req1 valid lit 8 for 3 cycles -> no push, req_ready=0, rr_ptr unchanged; then full deasserts -> lit 8 pushed that cycle.
- Flush mid-stream: after 3 pushes, assert flush while req2 valid lit 10.
  - Flush cycle: lit 10 is pushed; counters and rr_ptr read 0 on the next cycle.
  - Next grant searches from index 0.
